// File: rtl/bus_demux_stage_pkg.sv
// Shared definitions for the bus demux/mux family: idle-slice modes and bus_out slice indexing.
package bus_demux_stage_pkg;

  localparam int ZERO_IDLE_OFF = 0;
  localparam int ZERO_IDLE_ON  = 1;

  function automatic int slice_lo(int idx, int width);
    return idx * width;
  endfunction

endpackage

// File: rtl/onehot_decoder.sv
// Index-to-one-hot decoder; indices at or above N decode to all zeros.
module onehot_decoder
  import bus_demux_stage_pkg::*;
#(
  parameter int N   = 4,
  parameter int LOG = 2
) (
  input  logic [LOG-1:0] idx,
  input  logic           en,
  output logic [N-1:0]   onehot
);

  always_comb begin
    onehot = '0;
    for (int i = 0; i < N; i++) begin
      if (en && (idx == LOG'(i))) onehot[i] = 1'b1;
    end
  end

endmodule

// File: rtl/bus_demux_stage.sv
// Registered 1-to-NUM_BUSES demultiplexer with valid/ready flow control and one-beat holding register.
module bus_demux_stage
  import bus_demux_stage_pkg::*;
#(
  parameter int NUM_BUSES     = 4,
  parameter int NUM_BUSES_LOG = 2,
  parameter int BUS_WIDTH     = 256,
  parameter int ZERO_IDLE     = ZERO_IDLE_ON
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [NUM_BUSES_LOG-1:0]       in_select,
  input  logic [BUS_WIDTH-1:0]           in_data,
  output logic [NUM_BUSES-1:0]           out_valid,
  input  logic [NUM_BUSES-1:0]           out_ready,
  output logic [NUM_BUSES*BUS_WIDTH-1:0] bus_out,
  output logic                           bad_sel
);

  logic                     hold_valid_q, hold_valid_d;
  logic [NUM_BUSES_LOG-1:0] hold_sel_q, hold_sel_d;
  logic [BUS_WIDTH-1:0]     hold_data_q, hold_data_d;
  logic                     bad_sel_q, bad_sel_d;

  logic [NUM_BUSES-1:0] hold_onehot;
  logic                 accept;
  logic                 pop;
  logic                 sel_bad;

  onehot_decoder #(
    .N   (NUM_BUSES),
    .LOG (NUM_BUSES_LOG)
  ) u_hold_dec (
    .idx    (hold_sel_q),
    .en     (hold_valid_q),
    .onehot (hold_onehot)
  );

  // Only the ready of the channel currently holding a beat matters.
  assign pop      = |(hold_onehot & out_ready);
  assign in_ready = rst | ~hold_valid_q | pop;
  assign accept   = in_valid & in_ready;
  assign sel_bad  = int'(in_select) >= NUM_BUSES;

  always_comb begin
    hold_valid_d = hold_valid_q;
    hold_sel_d   = hold_sel_q;
    hold_data_d  = hold_data_q;
    bad_sel_d    = accept & sel_bad;
    if (accept && !sel_bad) begin
      hold_valid_d = 1'b1;
      hold_sel_d   = in_select;
      hold_data_d  = in_data;
    end else if (pop) begin
      hold_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_valid_q <= 1'b0;
      hold_sel_q   <= '0;
      hold_data_q  <= '0;
      bad_sel_q    <= 1'b0;
    end else begin
      hold_valid_q <= hold_valid_d;
      hold_sel_q   <= hold_sel_d;
      hold_data_q  <= hold_data_d;
      bad_sel_q    <= bad_sel_d;
    end
  end

  assign out_valid = hold_onehot;
  assign bad_sel   = bad_sel_q;

  for (genvar g = 0; g < NUM_BUSES; g++) begin : g_slice
    if (ZERO_IDLE != ZERO_IDLE_OFF) begin : g_zero
      assign bus_out[slice_lo(g, BUS_WIDTH) +: BUS_WIDTH] = hold_onehot[g] ? hold_data_q : '0;
    end else begin : g_hold
      assign bus_out[slice_lo(g, BUS_WIDTH) +: BUS_WIDTH] = hold_data_q;
    end
  end

endmodule

// File: tb/tb_bus_demux_stage.sv
// Directed table-driven bench for bus_demux_stage across default, 3-channel and held-data configurations.
module tb_bus_demux_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_ab, rst_c;

  // dut_a: 4 channels, 256 bits, zero idle
  logic         in_valid_a, in_ready_a, bad_a;
  logic [1:0]   in_select_a;
  logic [255:0] in_data_a;
  logic [3:0]   out_valid_a, out_ready_a;
  logic [1023:0] bus_a;

  // dut_b: 3 channels, 32 bits, zero idle
  logic        in_valid_b, in_ready_b, bad_b;
  logic [1:0]  in_select_b;
  logic [31:0] in_data_b;
  logic [2:0]  out_valid_b, out_ready_b;
  logic [95:0] bus_b;

  // dut_c: 4 channels, 16 bits, held data on all slices
  logic        in_valid_c, in_ready_c, bad_c;
  logic [1:0]  in_select_c;
  logic [15:0] in_data_c;
  logic [3:0]  out_valid_c, out_ready_c;
  logic [63:0] bus_c;

  bus_demux_stage #(.NUM_BUSES(4), .NUM_BUSES_LOG(2), .BUS_WIDTH(256), .ZERO_IDLE(1)) dut_a (
    .clk(clk), .rst(rst_ab), .in_valid(in_valid_a), .in_ready(in_ready_a),
    .in_select(in_select_a), .in_data(in_data_a), .out_valid(out_valid_a),
    .out_ready(out_ready_a), .bus_out(bus_a), .bad_sel(bad_a));

  bus_demux_stage #(.NUM_BUSES(3), .NUM_BUSES_LOG(2), .BUS_WIDTH(32), .ZERO_IDLE(1)) dut_b (
    .clk(clk), .rst(rst_ab), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .in_select(in_select_b), .in_data(in_data_b), .out_valid(out_valid_b),
    .out_ready(out_ready_b), .bus_out(bus_b), .bad_sel(bad_b));

  bus_demux_stage #(.NUM_BUSES(4), .NUM_BUSES_LOG(2), .BUS_WIDTH(16), .ZERO_IDLE(0)) dut_c (
    .clk(clk), .rst(rst_c), .in_valid(in_valid_c), .in_ready(in_ready_c),
    .in_select(in_select_c), .in_data(in_data_c), .out_valid(out_valid_c),
    .out_ready(out_ready_c), .bus_out(bus_c), .bad_sel(bad_c));

  int n_vec  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected dut_a bus: only the valid channel carries the replicated byte.
  task automatic chk_bus_a(input string nm, input logic [3:0] ov, input logic [7:0] byt);
    logic [255:0] exp;
    for (int s = 0; s < 4; s++) begin
      exp = ov[s] ? {32{byt}} : 256'd0;
      chk($sformatf("%s slice%0d", nm, s), bus_a[s*256 +: 256], exp);
    end
  endtask

  typedef struct {
    logic       vld;
    logic [1:0] sel;
    logic [7:0] byt;
    logic [3:0] rdy;
    logic       exp_ir;
    logic [3:0] exp_ov;
    logic [7:0] exp_byt;
  } vec_t;

  vec_t tbl[9];

  initial begin
    tbl[0] = '{1'b1, 2'd2, 8'hA5, 4'b0100, 1'b1, 4'b0100, 8'hA5};
    tbl[1] = '{1'b0, 2'd0, 8'h00, 4'b0100, 1'b1, 4'b0000, 8'h00};
    tbl[2] = '{1'b1, 2'd1, 8'h3C, 4'b0000, 1'b1, 4'b0010, 8'h3C};
    tbl[3] = '{1'b1, 2'd3, 8'hFF, 4'b0000, 1'b0, 4'b0010, 8'h3C};
    tbl[4] = '{1'b1, 2'd3, 8'hFF, 4'b1101, 1'b0, 4'b0010, 8'h3C};
    tbl[5] = '{1'b1, 2'd3, 8'hFF, 4'b0000, 1'b0, 4'b0010, 8'h3C};
    tbl[6] = '{1'b1, 2'd3, 8'hFF, 4'b0000, 1'b0, 4'b0010, 8'h3C};
    tbl[7] = '{1'b1, 2'd0, 8'h11, 4'b0010, 1'b1, 4'b0001, 8'h11};
    tbl[8] = '{1'b0, 2'd0, 8'h00, 4'b0001, 1'b1, 4'b0000, 8'h00};

    rst_ab = 1'b1; rst_c = 1'b1;
    in_valid_a = 1'b1; in_select_a = 2'd2; in_data_a = {256{1'b1}}; out_ready_a = 4'b0000;
    in_valid_b = 1'b0; in_select_b = 2'd0; in_data_b = 32'd0; out_ready_b = 3'b000;
    in_valid_c = 1'b0; in_select_c = 2'd0; in_data_c = 16'd0; out_ready_c = 4'b0000;
    #1;
    chk("rst in_ready", 256'(in_ready_a), 256'(1'b1));
    tick();
    tick();
    chk("rst out_valid", 256'(out_valid_a), 256'd0);
    chk("rst bad_sel", 256'(bad_a), 256'd0);
    chk_bus_a("rst bus", 4'b0000, 8'h00);
    rst_ab = 1'b0; rst_c = 1'b0; in_valid_a = 1'b0;
    tick();
    chk("post-rst out_valid", 256'(out_valid_a), 256'd0);

    for (int v = 0; v < 9; v++) begin
      in_valid_a  = tbl[v].vld;
      in_select_a = tbl[v].sel;
      in_data_a   = {32{tbl[v].byt}};
      out_ready_a = tbl[v].rdy;
      #1;
      chk($sformatf("vec%0d in_ready", v), 256'(in_ready_a), 256'(tbl[v].exp_ir));
      tick();
      chk($sformatf("vec%0d out_valid", v), 256'(out_valid_a), 256'(tbl[v].exp_ov));
      chk_bus_a($sformatf("vec%0d bus", v), tbl[v].exp_ov, tbl[v].exp_byt);
    end

    // Full-rate streaming: one beat per cycle, no bubbles.
    for (int i = 0; i < 16; i++) begin
      in_valid_a  = 1'b1;
      in_select_a = 2'(i % 4);
      in_data_a   = 256'(i);
      out_ready_a = 4'b1111;
      #1;
      chk($sformatf("stream%0d in_ready", i), 256'(in_ready_a), 256'(1'b1));
      tick();
      chk($sformatf("stream%0d out_valid", i), 256'(out_valid_a), 256'(4'b0001 << (i % 4)));
      for (int s = 0; s < 4; s++) begin
        chk($sformatf("stream%0d slice%0d", i, s), bus_a[s*256 +: 256],
            (s == i % 4) ? 256'(i) : 256'd0);
      end
    end
    in_valid_a = 1'b0;
    tick();
    chk("stream drain out_valid", 256'(out_valid_a), 256'd0);

    // Out-of-range select on a 3-channel stage.
    in_valid_b = 1'b1; in_select_b = 2'd3; in_data_b = 32'hDEADBEEF; out_ready_b = 3'b111;
    #1;
    chk("bad in_ready", 256'(in_ready_b), 256'(1'b1));
    tick();
    chk("bad bad_sel", 256'(bad_b), 256'(1'b1));
    chk("bad out_valid", 256'(out_valid_b), 256'd0);
    chk("bad bus", 256'(bus_b), 256'd0);
    in_select_b = 2'd0; in_data_b = 32'h0000BEEF;
    tick();
    chk("after bad bad_sel", 256'(bad_b), 256'd0);
    chk("after bad out_valid", 256'(out_valid_b), 256'(3'b001));
    chk("after bad bus", 256'(bus_b), 256'({64'd0, 32'h0000BEEF}));
    in_select_b = 2'd1; in_data_b = 32'h00000001; out_ready_b = 3'b001;
    #1;
    chk("b pop in_ready", 256'(in_ready_b), 256'(1'b1));
    tick();
    chk("b ch1 out_valid", 256'(out_valid_b), 256'(3'b010));
    chk("b ch1 bus", 256'(bus_b), 256'({32'd0, 32'h00000001, 32'd0}));
    in_select_b = 2'd3; in_data_b = 32'hFFFFFFFF; out_ready_b = 3'b010;
    tick();
    chk("bad w/ pop out_valid", 256'(out_valid_b), 256'd0);
    chk("bad w/ pop bad_sel", 256'(bad_b), 256'(1'b1));
    in_valid_b = 1'b0;
    tick();
    chk("bad pulse end", 256'(bad_b), 256'd0);

    // Held-data mode and reset while holding.
    in_valid_c = 1'b1; in_select_c = 2'd0; in_data_c = 16'h1234; out_ready_c = 4'b0000;
    tick();
    chk("c out_valid", 256'(out_valid_c), 256'(4'b0001));
    chk("c bus", 256'(bus_c), 256'({4{16'h1234}}));
    in_valid_c = 1'b0;
    tick();
    chk("c hold out_valid", 256'(out_valid_c), 256'(4'b0001));
    chk("c hold bus", 256'(bus_c), 256'({4{16'h1234}}));
    rst_c = 1'b1;
    tick();
    chk("c rst out_valid", 256'(out_valid_c), 256'd0);
    chk("c rst bus", 256'(bus_c), 256'd0);
    rst_c = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
